// File: rtl/shared_buffer_pkg.sv
// Shared definitions for the multi-channel shared-buffer FIFO and its neighbours
// (ingress arbiter, egress scheduler): width helpers and count-field layout.
package shared_buffer_pkg;

    // Default geometry of the shared buffer.
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_CH     = 4;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch < 2) ? 1 : clog2(num_ch);
    endfunction

    // Pointer width: per-channel address bits plus one wrap bit.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // LSB of channel ch's occupancy field inside the packed count bus.
    function automatic int count_lsb(input int ch, input int addr_width);
        return ch * ptr_width(addr_width);
    endfunction

    // Count-field layout for the default geometry.
    localparam int DEF_COUNT_FIELD_W = ptr_width(DEF_ADDR_WIDTH);
    localparam int DEF_COUNT_BUS_W   = DEF_NUM_CH * DEF_COUNT_FIELD_W;

endpackage

// File: rtl/shared_buffer_ram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
module shared_buffer_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port and registered read port; the output holds when not reading.
    // NOTE: the array and its output register carry no reset so they map onto block RAM;
    // validity of the contents is tracked by the controller's pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/shared_buffer_fifo_mc.sv
// Multi-channel FIFO controller: NUM_CH equal queues carved out of one shared
// dual-port RAM, one write and one read per cycle to any channel.
module shared_buffer_fifo_mc
    import shared_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    localparam int CH_WIDTH  = ch_width(NUM_CH),
    localparam int PTR_WIDTH = ptr_width(ADDR_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [CH_WIDTH-1:0]           wr_ch,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    input  logic [CH_WIDTH-1:0]           rd_ch,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic [NUM_CH-1:0]             full,
    output logic [NUM_CH-1:0]             empty,
    output logic [NUM_CH*PTR_WIDTH-1:0]   count,
    output logic                          wr_err,
    output logic                          rd_err
);

    localparam int RAM_ADDR_BITS = CH_WIDTH + ADDR_WIDTH;

    logic [PTR_WIDTH-1:0]        wr_ptr_q [NUM_CH];
    logic [PTR_WIDTH-1:0]        wr_ptr_d [NUM_CH];
    logic [PTR_WIDTH-1:0]        rd_ptr_q [NUM_CH];
    logic [PTR_WIDTH-1:0]        rd_ptr_d [NUM_CH];
    logic [NUM_CH-1:0]           full_q, full_d;
    logic [NUM_CH-1:0]           empty_q, empty_d;
    logic [NUM_CH*PTR_WIDTH-1:0] count_q, count_d;
    logic                        rd_pend_q, rd_pend_d;
    logic                        rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]       rd_data_q, rd_data_d;
    logic                        wr_err_q, wr_err_d;
    logic                        rd_err_q, rd_err_d;

    logic                        wr_acc;
    logic                        rd_acc;
    logic [RAM_ADDR_BITS-1:0]    ram_waddr;
    logic [RAM_ADDR_BITS-1:0]    ram_raddr;
    logic [DATA_WIDTH-1:0]       ram_rdata;

    // Accept decisions use the registered flags only, so a slot freed this
    // cycle cannot be reused until the next one; the RAM never sees a
    // same-address read and write.
    always_comb begin
        wr_acc    = wr_en && !full_q[wr_ch];
        rd_acc    = rd_en && !empty_q[rd_ch];
        ram_waddr = {wr_ch, wr_ptr_q[wr_ch][ADDR_WIDTH-1:0]};
        ram_raddr = {rd_ch, rd_ptr_q[rd_ch][ADDR_WIDTH-1:0]};
    end

    shared_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (RAM_ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (ram_waddr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    // Next pointers, flags and counts per channel, plus the read-return pipeline.
    // NOTE: every variable gets its default at the top so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        full_d     = full_q;
        empty_d    = empty_q;
        count_d    = count_q;
        rd_pend_d  = rd_acc;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? ram_rdata : rd_data_q;
        wr_err_d   = wr_en && !wr_acc;
        rd_err_d   = rd_en && !rd_acc;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            if (wr_acc && (wr_ch == CH_WIDTH'(c))) begin
                wr_ptr_d[c] = wr_ptr_q[c] + PTR_WIDTH'(1);
            end
            if (rd_acc && (rd_ch == CH_WIDTH'(c))) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PTR_WIDTH'(1);
            end
            empty_d[c] = (wr_ptr_d[c] == rd_ptr_d[c]);
            full_d[c]  = (wr_ptr_d[c][ADDR_WIDTH-1:0] == rd_ptr_d[c][ADDR_WIDTH-1:0])
                      && (wr_ptr_d[c][ADDR_WIDTH] != rd_ptr_d[c][ADDR_WIDTH]);
            count_d[count_lsb(c, ADDR_WIDTH) +: PTR_WIDTH] = wr_ptr_d[c] - rd_ptr_d[c];
        end
    end

    // State registers; reset empties every queue and cancels any in-flight read.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
            full_q     <= '0;
            empty_q    <= '1;
            count_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
            full_q     <= full_d;
            empty_q    <= empty_d;
            count_q    <= count_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            wr_err_q   <= wr_err_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign wr_err   = wr_err_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_shared_buffer_fifo_mc.sv
// Self-checking bench for shared_buffer_fifo_mc against a queue-based model.
module tb_shared_buffer_fifo_mc;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int PW = AW + 1;
    localparam int D  = 1 << AW;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [CW-1:0]     wr_ch;
    logic [DW-1:0]     wr_data;
    logic              rd_en;
    logic [CW-1:0]     rd_ch;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic [NC-1:0]     full;
    logic [NC-1:0]     empty;
    logic [NC*PW-1:0]  count;
    logic              wr_err;
    logic              rd_err;

    shared_buffer_fifo_mc #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_ch    (rd_ch),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .wr_err   (wr_err),
        .rd_err   (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one FIFO queue per channel plus the one-deep read return.
    logic [DW-1:0]    mq [NC][$];
    logic             m_pend;
    logic [DW-1:0]    m_pend_data;
    logic             exp_rd_valid;
    logic [DW-1:0]    exp_rd_data;
    logic             exp_wr_err;
    logic             exp_rd_err;
    logic [NC-1:0]    exp_full;
    logic [NC-1:0]    exp_empty;
    logic [NC*PW-1:0] exp_count;

    int checks;
    int failures;

    function automatic void refresh_flags();
        for (int c = 0; c < NC; c++) begin
            exp_full[c]             = (mq[c].size() == D);
            exp_empty[c]            = (mq[c].size() == 0);
            exp_count[c*PW +: PW]   = PW'(mq[c].size());
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) mq[c].delete();
        m_pend       = 1'b0;
        m_pend_data  = '0;
        exp_rd_valid = 1'b0;
        exp_rd_data  = '0;
        exp_wr_err   = 1'b0;
        exp_rd_err   = 1'b0;
        refresh_flags();
    endfunction

    // Drive one cycle of requests, advance the model, then sample 1 ns after the edge.
    task automatic step(input logic we, input logic [CW-1:0] wc, input logic [DW-1:0] wd,
                        input logic re, input logic [CW-1:0] rc);
        bit            wacc;
        bit            racc;
        logic [DW-1:0] popped;
        popped  = '0;
        wr_en   = we;
        wr_ch   = wc;
        wr_data = wd;
        rd_en   = re;
        rd_ch   = rc;
        wacc = we && (mq[wc].size() < D);
        racc = re && (mq[rc].size() > 0);
        if (racc) popped = mq[rc].pop_front();
        if (wacc) mq[wc].push_back(wd);
        exp_rd_valid = m_pend;
        if (m_pend) exp_rd_data = m_pend_data;
        m_pend      = racc;
        m_pend_data = popped;
        exp_wr_err  = we && !wacc;
        exp_rd_err  = re && !racc;
        refresh_flags();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic reset_assert();
        rst = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic reset_release();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wr_en = 1'b0; rd_en = 1'b0; wr_ch = '0; rd_ch = '0; wr_data = '0;
        reset_assert();
        checks++;
        if ({rd_valid, rd_data, wr_err, rd_err} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=%h", {rd_valid, rd_data, wr_err, rd_err}, 11'h0);
        end
        checks++;
        if ({full, empty, count} !== {4'h0, 4'hF, 20'h0}) begin
            failures++;
            $display("FAIL reset_flags got=%h exp=%h", {full, empty, count}, {4'h0, 4'hF, 20'h0});
        end
        reset_release();
    endtask

    task automatic test_fill_ch2();
        for (int i = 0; i <= D; i++) begin
            step(1'b1, 2'd2, DW'(8'h10 + i), 1'b0, '0);
            checks++;
            if ({full, empty, count} !== {exp_full, exp_empty, exp_count}) begin
                failures++;
                $display("FAIL fill_flags i=%0d got=%h exp=%h", i, {full, empty, count}, {exp_full, exp_empty, exp_count});
            end
            checks++;
            if ({rd_valid, wr_err, rd_err} !== {exp_rd_valid, exp_wr_err, exp_rd_err}) begin
                failures++;
                $display("FAIL fill_pulses i=%0d got=%b exp=%b", i, {rd_valid, wr_err, rd_err}, {exp_rd_valid, exp_wr_err, exp_rd_err});
            end
        end
        checks++;
        if ({full[2], count[2*PW +: PW], wr_err} !== {1'b1, 5'd16, 1'b1}) begin
            failures++;
            $display("FAIL fill_final got=%b exp=%b", {full[2], count[2*PW +: PW], wr_err}, {1'b1, 5'd16, 1'b1});
        end
    endtask

    task automatic test_drain_ch2();
        int got;
        got = 0;
        for (int i = 0; i < D + 3; i++) begin
            if (i <= D) step(1'b0, '0, '0, 1'b1, 2'd2);
            else        idle();
            checks++;
            if ({rd_valid, rd_data, wr_err, rd_err} !== {exp_rd_valid, exp_rd_data, exp_wr_err, exp_rd_err}) begin
                failures++;
                $display("FAIL drain_outs i=%0d got=%h exp=%h", i, {rd_valid, rd_data, wr_err, rd_err}, {exp_rd_valid, exp_rd_data, exp_wr_err, exp_rd_err});
            end
            checks++;
            if ({full, empty, count} !== {exp_full, exp_empty, exp_count}) begin
                failures++;
                $display("FAIL drain_flags i=%0d got=%h exp=%h", i, {full, empty, count}, {exp_full, exp_empty, exp_count});
            end
            if (rd_valid === 1'b1) begin
                checks++;
                if (rd_data !== DW'(8'h10 + got)) begin
                    failures++;
                    $display("FAIL drain_order n=%0d got=%h exp=%h", got, rd_data, DW'(8'h10 + got));
                end
                got++;
            end
            if (i == D) begin
                checks++;
                if ({rd_err, empty[2]} !== 2'b11) begin
                    failures++;
                    $display("FAIL drain_extra got=%b exp=%b", {rd_err, empty[2]}, 2'b11);
                end
            end
        end
        checks++;
        if (got != D) begin
            failures++;
            $display("FAIL drain_words got=%0d exp=%0d", got, D);
        end
    endtask

    task automatic test_wrap_ch0();
        int plan [4] = '{12, 12, 16, 16};
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < plan[ph]; i++) begin
                if (ph % 2 == 0) step(1'b1, 2'd0, DW'($urandom), 1'b0, '0);
                else             step(1'b0, '0, '0, 1'b1, 2'd0);
                checks++;
                if ({rd_valid, rd_data, wr_err, rd_err} !== {exp_rd_valid, exp_rd_data, exp_wr_err, exp_rd_err}) begin
                    failures++;
                    $display("FAIL wrap_outs ph=%0d i=%0d got=%h exp=%h", ph, i, {rd_valid, rd_data, wr_err, rd_err}, {exp_rd_valid, exp_rd_data, exp_wr_err, exp_rd_err});
                end
                checks++;
                if ({full, empty, count} !== {exp_full, exp_empty, exp_count}) begin
                    failures++;
                    $display("FAIL wrap_flags ph=%0d i=%0d got=%h exp=%h", ph, i, {full, empty, count}, {exp_full, exp_empty, exp_count});
                end
            end
        end
        idle();
        checks++;
        if ({rd_valid, rd_data, empty[0]} !== {exp_rd_valid, exp_rd_data, 1'b1}) begin
            failures++;
            $display("FAIL wrap_tail got=%h exp=%h", {rd_valid, rd_data, empty[0]}, {exp_rd_valid, exp_rd_data, 1'b1});
        end
    endtask

    task automatic test_simul_ch1();
        step(1'b1, 2'd1, 8'hA5, 1'b1, 2'd1);
        checks++;
        if ({wr_err, rd_err, count[1*PW +: PW]} !== {1'b0, 1'b1, 5'd1}) begin
            failures++;
            $display("FAIL simul_empty got=%b exp=%b", {wr_err, rd_err, count[1*PW +: PW]}, {1'b0, 1'b1, 5'd1});
        end
        for (int i = 0; i < D - 1; i++) step(1'b1, 2'd1, DW'($urandom), 1'b0, '0);
        checks++;
        if ({full[1], count[1*PW +: PW]} !== {1'b1, 5'd16}) begin
            failures++;
            $display("FAIL simul_fill got=%b exp=%b", {full[1], count[1*PW +: PW]}, {1'b1, 5'd16});
        end
        step(1'b1, 2'd1, 8'h5A, 1'b1, 2'd1);
        checks++;
        if ({wr_err, rd_err, full[1], count[1*PW +: PW]} !== {1'b1, 1'b0, 1'b0, 5'd15}) begin
            failures++;
            $display("FAIL simul_full got=%b exp=%b", {wr_err, rd_err, full[1], count[1*PW +: PW]}, {1'b1, 1'b0, 1'b0, 5'd15});
        end
        idle();
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL simul_data got=%h exp=%h", {rd_valid, rd_data}, {1'b1, 8'hA5});
        end
        for (int i = 0; i < D + 2; i++) begin
            if (i < D) step(1'b0, '0, '0, 1'b1, 2'd1);
            else       idle();
            checks++;
            if ({rd_valid, rd_data, rd_err, count} !== {exp_rd_valid, exp_rd_data, exp_rd_err, exp_count}) begin
                failures++;
                $display("FAIL simul_drain i=%0d got=%h exp=%h", i, {rd_valid, rd_data, rd_err, count}, {exp_rd_valid, exp_rd_data, exp_rd_err, exp_count});
            end
        end
    endtask

    task automatic test_interleave();
        for (int i = 0; i < D; i++) step(1'b1, 2'd3, DW'($urandom), 1'b0, '0);
        for (int i = 0; i < 64 + 2 * D; i++) begin
            if (i < 64)      step(1'b1, 2'd0, DW'($urandom), 1'b1, 2'd3);
            else if (i < 64 + D) step(1'b0, '0, '0, 1'b1, 2'd0);
            else             idle();
            checks++;
            if ({rd_valid, rd_data, wr_err, rd_err} !== {exp_rd_valid, exp_rd_data, exp_wr_err, exp_rd_err}) begin
                failures++;
                $display("FAIL inter_outs i=%0d got=%h exp=%h", i, {rd_valid, rd_data, wr_err, rd_err}, {exp_rd_valid, exp_rd_data, exp_wr_err, exp_rd_err});
            end
            checks++;
            if ({full, empty, count} !== {exp_full, exp_empty, exp_count}) begin
                failures++;
                $display("FAIL inter_flags i=%0d got=%h exp=%h", i, {full, empty, count}, {exp_full, exp_empty, exp_count});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), CW'($urandom), DW'($urandom),
                 1'($urandom_range(0, 1)), CW'($urandom));
            checks++;
            if ({rd_valid, rd_data, wr_err, rd_err} !== {exp_rd_valid, exp_rd_data, exp_wr_err, exp_rd_err}) begin
                failures++;
                $display("FAIL rand_outs i=%0d got=%h exp=%h", i, {rd_valid, rd_data, wr_err, rd_err}, {exp_rd_valid, exp_rd_data, exp_wr_err, exp_rd_err});
            end
            checks++;
            if ({full, empty, count} !== {exp_full, exp_empty, exp_count}) begin
                failures++;
                $display("FAIL rand_flags i=%0d got=%h exp=%h", i, {full, empty, count}, {exp_full, exp_empty, exp_count});
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) step(1'b1, 2'd3, DW'($urandom), 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 2'd3);
        // The read is now in flight; reset arrives mid-cycle before it returns.
        reset_assert();
        checks++;
        if ({rd_valid, full, empty, count} !== {1'b0, 4'h0, 4'hF, 20'h0}) begin
            failures++;
            $display("FAIL rstmid_now got=%h exp=%h", {rd_valid, full, empty, count}, {1'b0, 4'h0, 4'hF, 20'h0});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({rd_valid, rd_data, empty, count} !== {1'b0, 8'h00, 4'hF, 20'h0}) begin
            failures++;
            $display("FAIL rstmid_edge got=%h exp=%h", {rd_valid, rd_data, empty, count}, {1'b0, 8'h00, 4'hF, 20'h0});
        end
        reset_release();
        @(posedge clk);
        #1;
        step(1'b1, 2'd3, 8'hC3, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 2'd3);
        idle();
        checks++;
        if ({rd_valid, rd_data, empty[3]} !== {1'b1, 8'hC3, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_new got=%h exp=%h", {rd_valid, rd_data, empty[3]}, {1'b1, 8'hC3, 1'b1});
        end
        checks++;
        if ({rd_valid, rd_data} !== {exp_rd_valid, exp_rd_data}) begin
            failures++;
            $display("FAIL rstmid_model got=%h exp=%h", {rd_valid, rd_data}, {exp_rd_valid, exp_rd_data});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        test_reset();
        test_fill_ch2();
        test_drain_ch2();
        test_wrap_ch0();
        test_simul_ch1();
        test_interleave();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
